// File: rtl/nibble_uart_tx_pkg.sv
// Purpose : shared types and constants for the nibble UART transmitter.
// Latency : n/a (types only).
// Backpr. : n/a (types only).
package nibble_tx_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_e;

    localparam int   CLKS_PER_BIT_DEF = 8;

    // Serial line levels
    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/nibble_uart_tx_if.sv
// Purpose : read side of the upstream 4-bit FIFO (pop strobe, empty flag, data).
// Latency : fifo_data is valid the cycle after fifo_rd.
// Backpr. : fifo_empty=1 holds off pops; the transmitter never pops an empty FIFO.
//   master : transmitter side (drives fifo_rd)
//   slave  : FIFO side (drives fifo_empty, fifo_data)
interface nibble_uart_tx_if;
    logic       fifo_empty;
    logic [3:0] fifo_data;
    logic       fifo_rd;

    modport master (output fifo_rd, input fifo_empty, input fifo_data);
    modport slave  (input fifo_rd, output fifo_empty, output fifo_data);
endinterface

// File: rtl/nibble_uart_tx_baud_tick_gen.sv
// Purpose : bit-period timer; one-cycle tick every CLKS_PER_BIT cycles.
// Latency : first tick CLKS_PER_BIT cycles after i_restart is released.
// Backpr. : none; i_restart holds the counter at zero.
//   clk, rst_n : clock / async active-low reset
//   i_restart  : synchronous restart (counter forced to 0)
//   o_tick     : high in the last cycle of every bit period
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_restart,
    output logic o_tick
);

    localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

    logic [7:0] r_cnt;

    assign o_tick = (r_cnt == LAST_CNT);

    // Wrapping on the tick reloads the period at every bit boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (i_restart || o_tick) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/nibble_uart_tx.sv
// Purpose : serialises 4-bit FIFO entries as start/4 data (LSB first)/[even parity]/stop frames.
// Latency : empty falls in T -> pop T+1 -> capture T+2 -> start bit T+3; frames back-to-back with a 2-cycle gap.
// Backpr. : pops only when tx_en=1 and FIFO not empty; a started frame always completes.
//   clk, rst_n : clock / async active-low reset
//   tx_en      : allows new frames to start
//   fifo_if    : upstream FIFO read port (fifo_rd, fifo_empty, fifo_data)
//   tx_out     : serial line (registered, idle high)
//   busy       : high whenever the sequencer is not IDLE
//   frame_cnt  : completed frame count, wraps at 256
module nibble_uart_tx
    import nibble_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter bit PARITY_EN    = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tx_en,
    nibble_uart_tx_if.master        fifo_if,
    output logic                    tx_out,
    output logic                    busy,
    output logic [7:0]              frame_cnt
);

    state_e     r_state, w_state_nxt;
    logic [1:0] r_idx, w_idx_nxt;
    logic [3:0] r_sh, w_sh_nxt;
    logic       r_par, w_par_nxt;
    logic       r_tx, w_tx_nxt;
    logic [7:0] r_frame_cnt;
    logic       w_cnt_inc;
    logic       w_restart;
    logic       w_tick;
    logic       w_can_pop;

    assign w_can_pop      = tx_en && !fifo_if.fifo_empty;
    assign fifo_if.fifo_rd = (r_state == POP);
    assign busy           = (r_state != IDLE);
    assign tx_out         = r_tx;
    assign frame_cnt      = r_frame_cnt;

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= 2'd0;
            r_sh        <= 4'd0;
            r_par       <= 1'b0;
            r_tx        <= IDLE_LVL;
            r_frame_cnt <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_sh    <= w_sh_nxt;
            r_par   <= w_par_nxt;
            r_tx    <= w_tx_nxt;
            if (w_cnt_inc) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_sh_nxt    = r_sh;
        w_par_nxt   = r_par;
        w_cnt_inc   = 1'b0;
        w_restart   = 1'b0;

        case (r_state)
            IDLE: begin
                w_restart = 1'b1;
                if (w_can_pop) begin
                    w_state_nxt = POP;
                end
            end
            POP: begin
                // Empty may rise here; the pop is already committed.
                w_restart   = 1'b1;
                w_state_nxt = LOAD;
            end
            LOAD: begin
                // Holding the timer in restart here aligns tick with the end of START.
                w_restart   = 1'b1;
                w_sh_nxt    = fifo_if.fifo_data;
                w_par_nxt   = ^fifo_if.fifo_data;
                w_idx_nxt   = 2'd0;
                w_state_nxt = START;
            end
            START: begin
                if (w_tick) begin
                    w_idx_nxt   = 2'd0;
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_idx == 2'd3) begin
                        w_state_nxt = PARITY_EN ? PARITY : STOP;
                    end else begin
                        w_idx_nxt = r_idx + 2'd1;
                        w_sh_nxt  = {1'b0, r_sh[3:1]};
                    end
                end
            end
            PARITY: begin
                if (w_tick) begin
                    w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (w_tick) begin
                    w_cnt_inc   = 1'b1;
                    w_state_nxt = w_can_pop ? POP : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Line value is computed for the state being entered so tx_out comes
    // straight from a flop and lines up with the state it belongs to.
    always_comb begin
        w_tx_nxt = IDLE_LVL;
        case (w_state_nxt)
            START:   w_tx_nxt = START_LVL;
            DATA:    w_tx_nxt = w_sh_nxt[0];
            PARITY:  w_tx_nxt = r_par;
            STOP:    w_tx_nxt = STOP_LVL;
            default: w_tx_nxt = IDLE_LVL;
        endcase
    end

endmodule

// File: tb/tb_nibble_uart_tx.sv
// Purpose : randomized self-checking bench for nibble_uart_tx (CLKS_PER_BIT=4).
// Latency : n/a.
// Backpr. : n/a.
module tb_nibble_uart_tx;

    localparam int C = 4;

    logic       clk;
    logic       rst_n;
    logic       tx_en0, tx0, busy0;
    logic [7:0] cnt0;
    logic       tx_en1, tx1, busy1;
    logic [7:0] cnt1;

    nibble_uart_tx_if ifc0 ();
    nibble_uart_tx_if ifc1 ();

    nibble_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en0), .fifo_if(ifc0.master),
        .tx_out(tx0), .busy(busy0), .frame_cnt(cnt0)
    );

    nibble_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en1), .fifo_if(ifc1.master),
        .tx_out(tx1), .busy(busy1), .frame_cnt(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected line level at cycle c of a frame (c=0 is first start-bit cycle).
    function automatic logic exp_line(input logic [3:0] nib, input bit pe, input int c);
        int b;
        b = c / C;
        if (b == 0) return 1'b0;
        if (b <= 4) return nib[b-1];
        if (b == 5 && pe) return ^nib;
        return 1'b1;
    endfunction

    // Upstream FIFO models
    logic [3:0] mem0 [0:1023];
    logic [3:0] mem1 [0:63];
    int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;

    assign ifc0.fifo_empty = (wr0 == rd0);
    assign ifc1.fifo_empty = (wr1 == rd1);

    always @(posedge clk) begin
        if (ifc0.fifo_rd) begin
            ifc0.fifo_data <= mem0[rd0];
            rd0 <= rd0 + 1;
        end
        if (ifc1.fifo_rd) begin
            ifc1.fifo_data <= mem1[rd1];
            rd1 <= rd1 + 1;
        end
    end

    // Reference model for DUT0: per-cycle expected line queue built at each pop.
    bit         lq[$];
    bit         lastq[$];
    logic [7:0] exp_cnt = 8'd0;
    int         m_rd = 0;
    bit         pop_next = 0;
    bit         m_exp_rd, m_had, m_tx, m_last;
    logic [3:0] m_nib;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_tx", tx0, 1);
            chk("rst_rd", ifc0.fifo_rd, 0);
            chk("rst_busy", busy0, 0);
            chk("rst_cnt", cnt0, 0);
            lq.delete();
            lastq.delete();
            exp_cnt  = 8'd0;
            pop_next = 0;
        end else begin
            m_exp_rd = pop_next;
            m_had    = (lq.size() != 0);
            m_tx     = 1'b1;
            m_last   = 1'b0;
            if (m_had) begin
                m_tx   = lq.pop_front();
                m_last = lastq.pop_front();
            end
            chk("tx", tx0, m_tx);
            chk("rd", ifc0.fifo_rd, m_exp_rd);
            chk("busy", busy0, m_had || m_exp_rd);
            chk("cnt", cnt0, exp_cnt);
            if (m_last) exp_cnt = exp_cnt + 8'd1;
            if (m_exp_rd) begin
                m_nib = mem0[m_rd];
                m_rd++;
                lq.push_back(1'b1);
                lastq.push_back(1'b0);
                for (int c = 0; c < 7 * C; c++) begin
                    lq.push_back(exp_line(m_nib, 1'b1, c));
                    lastq.push_back(c == 7 * C - 1);
                end
            end
            pop_next = ((!m_had && !m_exp_rd) || m_last) && tx_en0 && (wr0 != m_rd);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [3:0] d);
        mem0[wr0] = d;
        wr0++;
    endtask

    task automatic drain0(input int maxc);
        int i;
        i = 0;
        while ((wr0 != rd0 || busy0) && i < maxc) begin
            step();
            i++;
        end
        chk("drain_timeout", (i < maxc), 1);
    endtask

    task automatic wait_rd0(input int maxc);
        int i;
        i = 0;
        while (!ifc0.fifo_rd && i < maxc) begin
            step();
            i++;
        end
        chk("rd_timeout", ifc0.fifo_rd, 1);
    endtask

    logic [3:0]  nib;
    logic [7:0]  c0;
    int          rb;
    int          k;

    initial begin
        rst_n  = 1'b0;
        tx_en0 = 1'b1;
        tx_en1 = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();

        // No-parity instance: 24-cycle frames, then idle.
        for (int n = 0; n < 3; n++) begin
            nib = (n == 0) ? 4'h7 : 4'($urandom);
            mem1[wr1] = nib;
            wr1++;
            k = 0;
            while (k < 10) begin
                @(negedge clk);
                if (ifc1.fifo_rd) break;
                k++;
            end
            chk("np_rd", ifc1.fifo_rd, 1);
            @(negedge clk);
            chk("np_load", tx1, 1);
            for (int c = 0; c < 6 * C; c++) begin
                @(negedge clk);
                chk("np_bit", tx1, exp_line(nib, 1'b0, c));
            end
            @(negedge clk);
            chk("np_busy_end", busy1, 0);
            chk("np_cnt", cnt1, n + 1);
            step();
        end

        // Single frames 0xA then 0x7.
        push0(4'hA);
        drain0(100);
        chk("single_cnt", cnt0, 1);
        push0(4'h7);
        drain0(100);
        chk("par7_cnt", cnt0, 2);

        // Back-to-back: three queued.
        for (int i = 0; i < 3; i++) push0(4'($urandom));
        drain0(200);
        chk("b2b_cnt", cnt0, 5);

        // Enable dropped mid DATA.
        c0 = exp_cnt;
        rb = rd0;
        for (int i = 0; i < 3; i++) push0(4'($urandom));
        wait_rd0(20);
        repeat (12) step();
        tx_en0 = 1'b0;
        repeat (40) step();
        chk("en_cnt", cnt0, 8'(c0 + 8'd1));
        chk("en_pops", rd0 - rb, 1);
        tx_en0 = 1'b1;
        drain0(200);
        chk("en_resume", cnt0, 8'(c0 + 8'd3));

        // Random traffic with enable toggling.
        for (int it = 0; it < 40; it++) begin
            tx_en0 = ($urandom_range(0, 3) != 0);
            for (int p = 0, np = $urandom_range(0, 2); p < np; p++) push0(4'($urandom));
            repeat ($urandom_range(1, 40)) step();
        end
        tx_en0 = 1'b1;
        drain0(3000);
        chk("rand_cnt", cnt0, exp_cnt);

        // Reset during PARITY (nibble 0x3 -> parity bit 0).
        push0(4'h3);
        wait_rd0(20);
        repeat (23) step();
        chk("par_pre", tx0, 0);
        rst_n = 1'b0;
        #1;
        chk("arst_tx", tx0, 1);
        chk("arst_busy", busy0, 0);
        chk("arst_cnt", cnt0, 0);
        chk("arst_rd", ifc0.fifo_rd, 0);
        rb = rd0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (5) step();
        chk("arst_nopop", rd0 - rb, 0);

        // Wrap after 256 frames.
        rb = rd0;
        for (int i = 0; i < 256; i++) push0(4'($urandom));
        drain0(9000);
        chk("wrap_pops", rd0 - rb, 256);
        chk("wrap_cnt", cnt0, 0);

        repeat (4) step();
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
